cliff_game_core: RTL and testbench

- Parametrised successor of the LED-strip cliff game.
- A group of GROUP_W lit LEDs sits on a STRIP_W strip between two adjustable walls.
- Once running, the group drifts one step per game tick in the last-chosen direction. Touching a wall loses.
- All timing uses clock enables on the single system clock, with no derived clocks. The block also adds score and best-score tracking, per-game wall latching, and a blinking lose display.
- It sits between the button debouncers (which supply single-cycle pulses) and the LED and seven-segment drivers.

---
 rtl/cliff_pkg.sv | 29 ++
 rtl/cliff_tick_gen.sv | 22 ++
 rtl/cliff_game_core.sv | 175 +++++++++++++++++
 tb/tb_cliff_game_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cliff_pkg.sv
// Shared encodings and the speed-to-period mapping for the cliff game core.
package cliff_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOST = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    localparam logic [1:0] SPEED_MAX = 2'd2;

    function automatic int unsigned tick_period(input logic [1:0] spd,
                                                input int unsigned t0,
                                                input int unsigned t1,
                                                input int unsigned t2);
        case (spd)
            2'd0:    return t0;
            2'd1:    return t1;
            default: return t2;
        endcase
    endfunction

endpackage

// File: rtl/cliff_tick_gen.sv
// Clock-enable generator: counts 0..period-1 and pulses tick at the terminal count.
module cliff_tick_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);
    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == period - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
endmodule

// File: rtl/cliff_game_core.sv
// LED-strip cliff game: a drifting group between two walls, with score, best score and lose blink.
module cliff_game_core
    import cliff_pkg::*;
#(
    parameter int          STRIP_W   = 16,
    parameter int          GROUP_W   = 3,
    parameter int          START_POS = 6,
    parameter int          WALL_W    = 3,
    parameter int unsigned TICK0     = 50_000_000,
    parameter int unsigned TICK1     = 12_500_000,
    parameter int unsigned TICK2     = 5_000_000,
    parameter int unsigned BLINK_DIV = 5_000_000,
    parameter int          SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_p,
    input  logic               left_p,
    input  logic               right_p,
    input  logic               up_p,
    input  logic               down_p,
    input  logic [WALL_W-1:0]  wall_l,
    input  logic [WALL_W-1:0]  wall_r,
    output logic [STRIP_W-1:0] led,
    output logic [1:0]         state,
    output logic [1:0]         speed,
    output logic [1:0]         dir,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic               lose
);
    localparam int          PW       = $clog2(STRIP_W);
    localparam int          EW       = PW + 2;
    localparam int unsigned TICK_MAX = (TICK0 > TICK1) ? ((TICK0 > TICK2) ? TICK0 : TICK2)
                                                       : ((TICK1 > TICK2) ? TICK1 : TICK2);
    localparam int          TW       = $clog2(TICK_MAX + 1);
    localparam int          BW       = $clog2(BLINK_DIV + 1);
    localparam logic [EW-1:0]      GM1   = EW'(GROUP_W - 1);
    localparam logic [STRIP_W-1:0] GMASK = STRIP_W'((1 << GROUP_W) - 1);

    state_t             state_q;
    dir_t               dir_q;
    logic [1:0]         speed_q;
    logic [PW-1:0]      pos_q, wl_q, wr_q, wl_in, wr_in;
    logic [SCORE_W-1:0] score_q, best_q;
    logic               lose_q, blink_on;
    logic               game_tick, blink_tick, spd_up, spd_dn;
    logic [TW-1:0]      game_period;
    logic [EW-1:0]      pe, wle, wre, pos_up, pos_dn, mv;
    logic               ins_now, ok_up, ok_dn, hit;
    logic [STRIP_W-1:0] grp, walls;

    assign wl_in = PW'(STRIP_W - 1) - PW'(wall_l);
    assign wr_in = PW'(wall_r);
    assign spd_up = up_p && !down_p && (speed_q != SPEED_MAX);
    assign spd_dn = down_p && !up_p && (speed_q != 2'd0);
    assign game_period = TW'(tick_period(speed_q, TICK0, TICK1, TICK2));

    cliff_tick_gen #(.CNT_W(TW)) u_game_tick (
        .clk(clk), .reset(reset), .clear((state_q != S_RUN) || spd_up || spd_dn),
        .en(state_q == S_RUN), .period(game_period), .tick(game_tick)
    );

    cliff_tick_gen #(.CNT_W(BW)) u_blink_tick (
        .clk(clk), .reset(reset), .clear(state_q != S_LOST),
        .en(state_q == S_LOST), .period(BW'(BLINK_DIV)), .tick(blink_tick)
    );

    // Geometry in a wider width so pos-1 at 0 and pos+width never wrap silently.
    always_comb begin
        pe      = EW'(pos_q);
        wle     = EW'(wl_q);
        wre     = EW'(wr_q);
        pos_up  = pe + EW'(1);
        pos_dn  = pe - EW'(1);
        ins_now = (pe > wre) && (pe + GM1 < wle);
        ok_up   = (pos_up > wre) && (pos_up + GM1 < wle);
        ok_dn   = (pe != '0) && (pos_dn > wre) && (pos_dn + GM1 < wle);
        mv      = (dir_q == DIR_LEFT) ? pos_up : pos_dn;
        hit     = (mv <= wre) || (mv + GM1 >= wle);
    end

    assign grp   = GMASK << pos_q;
    assign walls = (STRIP_W'(1) << wl_q) | (STRIP_W'(1) << wr_q);

    always_comb begin
        case (state_q)
            S_IDLE:  led = grp | walls;
            S_RUN:   led = grp;
            default: led = blink_on ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pos_q    <= PW'(START_POS);
            dir_q    <= DIR_NONE;
            speed_q  <= 2'd0;
            score_q  <= '0;
            best_q   <= '0;
            lose_q   <= 1'b0;
            blink_on <= 1'b1;
            wl_q     <= wl_in;
            wr_q     <= wr_in;
        end else begin
            if (spd_up)
                speed_q <= speed_q + 2'd1;
            else if (spd_dn)
                speed_q <= speed_q - 2'd1;

            if (state_q != S_LOST)
                blink_on <= 1'b1;
            else if (blink_tick)
                blink_on <= !blink_on;

            if (state_q == S_IDLE) begin
                wl_q <= wl_in;
                wr_q <= wr_in;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_p && ins_now) begin
                        state_q <= S_RUN;
                        score_q <= '0;
                        dir_q   <= DIR_NONE;
                    end else if (left_p && !right_p && ok_up) begin
                        pos_q <= pos_q + PW'(1);
                    end else if (right_p && !left_p && ok_dn) begin
                        pos_q <= pos_q - PW'(1);
                    end
                end
                S_RUN: begin
                    if (start_p) begin
                        state_q <= S_IDLE;
                        pos_q   <= PW'(START_POS);
                        dir_q   <= DIR_NONE;
                        speed_q <= 2'd0;
                    end else if (game_tick) begin
                        if (dir_q != DIR_NONE) begin
                            pos_q <= mv[PW-1:0];
                            if (hit) begin
                                state_q <= S_LOST;
                                lose_q  <= 1'b1;
                                if (score_q > best_q)
                                    best_q <= score_q;
                            end else if (score_q != '1) begin
                                score_q <= score_q + SCORE_W'(1);
                            end
                        end
                    end else if (left_p != right_p) begin
                        dir_q <= left_p ? DIR_LEFT : DIR_RIGHT;
                    end
                end
                default: begin
                    if (start_p) begin
                        state_q <= S_IDLE;
                        lose_q  <= 1'b0;
                        pos_q   <= PW'(START_POS);
                        dir_q   <= DIR_NONE;
                        speed_q <= 2'd0;
                    end
                end
            endcase
        end
    end

    assign state = state_q;
    assign dir   = dir_q;
    assign speed = speed_q;
    assign score = score_q;
    assign best  = best_q;
    assign lose  = lose_q;
endmodule

// File: tb/tb_cliff_game_core.sv
// Scoreboard bench for cliff_game_core: directed game scenarios followed by random button traffic.
module tb_cliff_game_core;
    localparam int T0 = 8, T1 = 4, T2 = 2, BD = 4;
    localparam int SW = 16, G = 3, SP = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start_p = 1'b0, left_p = 1'b0, right_p = 1'b0;
    logic        up_p = 1'b0, down_p = 1'b0;
    logic [2:0]  wall_l = 3'd0, wall_r = 3'd0;
    logic [15:0] led, score, best;
    logic [1:0]  state, speed, dir;
    logic        lose;

    always #5 clk = ~clk;

    cliff_game_core #(
        .STRIP_W(SW), .GROUP_W(G), .START_POS(SP), .WALL_W(3),
        .TICK0(T0), .TICK1(T1), .TICK2(T2), .BLINK_DIV(BD), .SCORE_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start_p(start_p), .left_p(left_p), .right_p(right_p),
        .up_p(up_p), .down_p(down_p), .wall_l(wall_l), .wall_r(wall_r),
        .led(led), .state(state), .speed(speed), .dir(dir),
        .score(score), .best(best), .lose(lose)
    );

    typedef struct {
        int led, st, spd, dir, score, best, lose;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;

    // Reference game: plain integers describing the game as the rules state it.
    int m_st, m_pos, m_dir, m_spd, m_score, m_best, m_wl, m_wr, m_tc, m_bc;
    bit m_blink;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit fits(int p);
        return (p > m_wr) && (p + G - 1 < m_wl);
    endfunction

    function automatic int exp_led();
        int v;
        v = 0;
        if (m_st == 2) return m_blink ? 16'hFFFF : 0;
        for (int i = 0; i < SW; i++)
            if (i >= m_pos && i < m_pos + G) v |= (1 << i);
        if (m_st == 0) v |= (1 << m_wl) | (1 << m_wr);
        return v;
    endfunction

    task automatic model(bit rs, bit s, bit l, bit r, bit u, bit d, int wli, int wri);
        int per, np, n_st, n_pos, n_dir, n_spd, n_score, n_best, n_tc, n_bc;
        bit tk, bt, chg, n_blink;
        if (rs) begin
            m_st = 0; m_pos = SP; m_dir = 0; m_spd = 0; m_score = 0; m_best = 0;
            m_tc = 0; m_bc = 0; m_blink = 1; m_wl = SW - 1 - wli; m_wr = wri;
            return;
        end
        per = (m_spd == 0) ? T0 : (m_spd == 1) ? T1 : T2;
        tk  = (m_st == 1) && (m_tc == per - 1);
        bt  = (m_st == 2) && (m_bc == BD - 1);
        n_spd = m_spd; chg = 0;
        if (u && !d && m_spd < 2) begin n_spd = m_spd + 1; chg = 1; end
        if (d && !u && m_spd > 0) begin n_spd = m_spd - 1; chg = 1; end
        n_tc    = (m_st != 1 || chg) ? 0 : (tk ? 0 : m_tc + 1);
        n_bc    = (m_st != 2) ? 0 : (bt ? 0 : m_bc + 1);
        n_blink = (m_st != 2) ? 1'b1 : (bt ? !m_blink : m_blink);
        n_st = m_st; n_pos = m_pos; n_dir = m_dir; n_score = m_score; n_best = m_best;
        case (m_st)
            0: begin
                if (s && fits(m_pos)) begin n_st = 1; n_score = 0; n_dir = 0; end
                else if (l && !r && fits(m_pos + 1)) n_pos = m_pos + 1;
                else if (r && !l && fits(m_pos - 1)) n_pos = m_pos - 1;
            end
            1: begin
                if (s) begin n_st = 0; n_pos = SP; n_dir = 0; n_spd = 0; end
                else if (tk) begin
                    if (m_dir != 0) begin
                        np = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
                        n_pos = np;
                        if (np <= m_wr || np + G - 1 >= m_wl) begin
                            n_st = 2;
                            if (m_score > m_best) n_best = m_score;
                        end else if (m_score < 65535) n_score = m_score + 1;
                    end
                end else if (l != r) n_dir = l ? 1 : 2;
            end
            default: if (s) begin n_st = 0; n_pos = SP; n_dir = 0; n_spd = 0; end
        endcase
        if (m_st == 0) begin m_wl = SW - 1 - wli; m_wr = wri; end
        m_st = n_st; m_pos = n_pos; m_dir = n_dir; m_spd = n_spd; m_score = n_score;
        m_best = n_best; m_tc = n_tc; m_bc = n_bc; m_blink = n_blink;
    endtask

    task automatic step(bit rs, bit s, bit l, bit r, bit u, bit d);
        exp_t e;
        reset = rs; start_p = s; left_p = l; right_p = r; up_p = u; down_p = d;
        @(posedge clk);
        model(rs, s, l, r, u, d, int'(wall_l), int'(wall_r));
        e.led = exp_led(); e.st = m_st; e.spd = m_spd; e.dir = m_dir;
        e.score = m_score; e.best = m_best; e.lose = (m_st == 2) ? 1 : 0;
        q.push_back(e);
        #1;
        reset = 0; start_p = 0; left_p = 0; right_p = 0; up_p = 0; down_p = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_led", int'(led), e.led);
            chk("sb_state", int'(state), e.st);
            chk("sb_speed", int'(speed), e.spd);
            chk("sb_dir", int'(dir), e.dir);
            chk("sb_score", int'(score), e.score);
            chk("sb_best", int'(best), e.best);
            chk("sb_lose", int'(lose), e.lose);
        end
    end

    initial begin
        int k;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        chk("reset_led", int'(led), 16'h81C1);
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_best", int'(best), 0);

        repeat (3) begin step(0, 0, 1, 0, 0, 0); idle(1); end
        chk("idle_left3", int'(led), 16'h8E01);
        wall_l = 3'd3; idle(2);
        step(0, 0, 1, 0, 0, 0); idle(1);
        chk("wall_refuse", int'(led), 16'h1E01);
        wall_l = 3'd0; idle(2);
        repeat (3) begin step(0, 0, 0, 1, 0, 0); idle(1); end
        chk("back_home", int'(led), 16'h81C1);

        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (k = 0; k < 200 && state != 2'd2; k++) idle(1);
        chk("lost_state", int'(state), 2);
        chk("lost_score", int'(score), 6);
        chk("lost_best", int'(best), 6);
        chk("lost_led_on", int'(led), 16'hFFFF);
        chk("lost_flag", int'(lose), 1);
        idle(4);
        chk("lost_led_off", int'(led), 0);

        step(0, 1, 0, 0, 0, 0);
        chk("restart_state", int'(state), 0);
        chk("restart_score", int'(score), 6);
        chk("restart_led", int'(led), 16'h81C1);

        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        chk("speed_sat_hi", int'(speed), 2);
        repeat (3) step(0, 0, 0, 0, 0, 1);
        chk("speed_sat_lo", int'(speed), 0);
        step(0, 0, 1, 0, 0, 0);
        for (k = 0; k < 100 && score != 16'd3; k++) idle(1);
        chk("run_score3", int'(score), 3);
        step(0, 1, 0, 0, 0, 0);
        chk("abort_state", int'(state), 0);
        chk("abort_best", int'(best), 6);
        chk("abort_score", int'(score), 3);

        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(10);
        step(1, 0, 0, 0, 0, 0);
        chk("midrun_reset_state", int'(state), 0);
        chk("midrun_reset_best", int'(best), 0);
        chk("midrun_reset_led", int'(led), 16'h81C1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                wall_l = 3'($urandom_range(0, 4));
                wall_r = 3'($urandom_range(0, 4));
            end
            step($urandom_range(0, 699) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
